// File: rtl/smm1_operand_loader_if.sv
// ----------------------------------------------------------------------------
// smm1_operand_loader_if
//
// Purpose: bundles the element stream and the multiplier-facing outputs of
// the SMM1 operand loader into one interface.
//
// Handshake: a beat is transferred on a rising clk edge where in_valid and
// in_ready are both high. in_valid with in_ready low has no effect, and the
// source must hold in_data/in_last/in_mode until the beat is taken. in_ready
// may drop or rise regardless of in_valid. in_valid may be low on any cycle,
// including in the middle of a frame.
//
// Signals:
//   in_data      element value (two's complement, pass-through)
//   in_valid     in_data/in_last/in_mode are valid this cycle
//   in_last      final beat (beat 31) of a frame
//   in_mode      sel value for the frame, used on beat 0 only
//   in_ready     loader accepts a beat this cycle
//   A, B         flat 4x4 operand buses, element (r,c) at (r*4+c)*DATAWIDTH
//   load         one-cycle pulse, A and B complete and stable
//   sel          mode to the multiplier
//   busy         high from load through result_valid, inclusive
//   result_valid one-cycle pulse when the multiplier result is due
//   frame_err    one-cycle pulse when a frame is dropped
//
// Modports: master = stream source / result consumer, slave = the loader.
// ----------------------------------------------------------------------------
interface smm1_operand_loader_if #(
    parameter int DATAWIDTH = 32
);
    localparam int BUSWIDTH = DATAWIDTH * 16;

    logic [DATAWIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_mode;
    logic                 in_ready;
    logic [BUSWIDTH-1:0]  A;
    logic [BUSWIDTH-1:0]  B;
    logic                 load;
    logic                 sel;
    logic                 busy;
    logic                 result_valid;
    logic                 frame_err;

    modport master (
        output in_data, in_valid, in_last, in_mode,
        input  in_ready, A, B, load, sel, busy, result_valid, frame_err
    );

    modport slave (
        input  in_data, in_valid, in_last, in_mode,
        output in_ready, A, B, load, sel, busy, result_valid, frame_err
    );
endinterface

// File: rtl/smm1_operand_loader.sv
// ----------------------------------------------------------------------------
// smm1_operand_loader
//
// Purpose: upstream feeder for the 4x4 Strassen multiplier stage. Collects a
// 32-beat row-major stream (16 A elements, then 16 B elements) into the flat
// A/B operand buses, issues a single-cycle load, then blocks input until the
// multiplier result is due LATENCY cycles later and flags it with
// result_valid. Malformed frames (in_last early or missing) are dropped with
// a frame_err pulse; data already written is left in place.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   bus        smm1_operand_loader_if.slave (stream in, operands/status out)
//   dbg_state  current FSM state (0 FILL, 1 ISSUE, 2 WAIT)
//
// Parameters:
//   DATAWIDTH  element width in bits
//   LATENCY    cycles from load to a valid multiplier result, must be >= 1
// ----------------------------------------------------------------------------
module smm1_operand_loader #(
    parameter int DATAWIDTH = 32,
    parameter int LATENCY   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    smm1_operand_loader_if.slave   bus,
    output logic [1:0]             dbg_state
);

    // A one-bit counter is kept even for LATENCY=1, where it goes unused.
    localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [4:0]                  beat_q, beat_d;
    logic [WAIT_W-1:0]           wait_q, wait_d;
    logic [15:0][DATAWIDTH-1:0]  a_q, a_d;
    logic [15:0][DATAWIDTH-1:0]  b_q, b_d;
    logic                        sel_q, sel_d;
    logic                        in_ready_q, in_ready_d;
    logic                        load_q, load_d;
    logic                        busy_q, busy_d;
    logic                        result_valid_q, result_valid_d;
    logic                        frame_err_q, frame_err_d;
    logic                        accept;

    // in_ready_q resets high so the loader is ready the moment rst drops;
    // gating with rst keeps in_ready low for as long as rst is asserted.
    assign bus.in_ready = in_ready_q && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        wait_d         = wait_q;
        a_d            = a_q;
        b_d            = b_q;
        sel_d          = sel_q;
        in_ready_d     = in_ready_q;
        load_d         = 1'b0;
        busy_d         = busy_q;
        result_valid_d = 1'b0;
        frame_err_d    = 1'b0;

        case (state_q)
            S_FILL: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (accept) begin
                    // Beats 0..15 fill A, 16..31 fill B, row-major.
                    if (beat_q[4]) begin
                        b_d[beat_q[3:0]] = bus.in_data;
                    end else begin
                        a_d[beat_q[3:0]] = bus.in_data;
                    end
                    if (beat_q == 5'd0) begin
                        sel_d = bus.in_mode;
                    end
                    if (beat_q == 5'd31) begin
                        beat_d = 5'd0;
                        if (bus.in_last) begin
                            state_d    = S_ISSUE;
                            in_ready_d = 1'b0;
                            load_d     = 1'b1;
                            busy_d     = 1'b1;
                        end else begin
                            // Missing last: drop the frame, keep the data.
                            frame_err_d = 1'b1;
                        end
                    end else if (bus.in_last) begin
                        // Early last: drop the frame, keep the data.
                        beat_d      = 5'd0;
                        frame_err_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end
            end

            S_ISSUE: begin
                busy_d = 1'b1;
                if (LATENCY == 1) begin
                    // Result is due right after the load cycle, so the
                    // loader reopens in the same cycle result_valid fires.
                    state_d        = S_FILL;
                    in_ready_d     = 1'b1;
                    result_valid_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    wait_d  = WAIT_W'(LATENCY - 1);
                end
            end

            S_WAIT: begin
                busy_d = 1'b1;
                if (wait_q == WAIT_W'(1)) begin
                    // Outputs are registered: raise result_valid for the
                    // cycle in which the counter shows 0.
                    wait_d         = '0;
                    result_valid_d = 1'b1;
                end else if (wait_q == '0) begin
                    state_d    = S_FILL;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end

            default: begin
                state_d    = S_FILL;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_FILL;
            beat_q         <= 5'd0;
            wait_q         <= '0;
            a_q            <= '0;
            b_q            <= '0;
            sel_q          <= 1'b0;
            in_ready_q     <= 1'b1;
            load_q         <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            wait_q         <= wait_d;
            a_q            <= a_d;
            b_q            <= b_d;
            sel_q          <= sel_d;
            in_ready_q     <= in_ready_d;
            load_q         <= load_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign bus.A            = a_q;
    assign bus.B            = b_q;
    assign bus.load         = load_q;
    assign bus.sel          = sel_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.frame_err    = frame_err_q;
    assign dbg_state        = state_q;

endmodule
